jtframe_led_fader: RTL and testbench



---
 rtl/jtframe_led_fader.sv | 132 +++++++++++++
 tb/tb_jtframe_led_fader.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/jtframe_led_fader.sv
// jtframe_led_fader
// Activity-LED driver fed by the pulse stretcher. While act_in is high the
// LED is solid on. When activity ends the brightness ramps linearly down to
// off through a PWM output. One brightness step is taken every 2^DIVW cen
// ticks. The PWM counter itself runs on every clk.

module jtframe_led_fader #(
    parameter int PWMW = 8,   // brightness / PWM resolution in bits
    parameter int DIVW = 6    // fade prescaler width (must be >= 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cen,
    input  logic            act_in,
    output logic            led,
    output logic [PWMW-1:0] level,
    output logic            busy
);

    // Brightness and divider constants, all at their natural widths.
    localparam logic [PWMW-1:0] LVL_ZERO = {PWMW{1'b0}};
    localparam logic [PWMW-1:0] LVL_ONE  = {{(PWMW-1){1'b0}}, 1'b1};
    localparam logic [PWMW-1:0] LVL_MAX  = {PWMW{1'b1}};
    localparam logic [DIVW-1:0] DIV_ZERO = {DIVW{1'b0}};
    localparam logic [DIVW-1:0] DIV_ONE  = {{(DIVW-1){1'b0}}, 1'b1};
    localparam logic [DIVW-1:0] DIV_MAX  = {DIVW{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_FADE = 2'd2
    } state_t;

    state_t            state_q,   state_d;
    logic [PWMW-1:0]   level_q,   level_d;
    logic [DIVW-1:0]   div_q,     div_d;
    logic [PWMW-1:0]   pwm_cnt_q, pwm_cnt_d;
    logic              led_q,     led_d;

    // Fader state machine: next state, brightness and prescaler.
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        div_d   = div_q;
        case (state_q)
            ST_IDLE: begin
                div_d = DIV_ZERO;
                if (act_in) begin
                    state_d = ST_ON;
                    level_d = LVL_MAX;
                end else begin
                    state_d = ST_IDLE;
                    level_d = LVL_ZERO;
                end
            end
            ST_ON: begin
                // Brightness pinned at full scale, prescaler parked at 0 so
                // the first fade step is exactly 2^DIVW cen ticks away.
                level_d = LVL_MAX;
                div_d   = DIV_ZERO;
                if (act_in) begin
                    state_d = ST_ON;
                end else begin
                    state_d = ST_FADE;
                end
            end
            ST_FADE: begin
                if (act_in) begin
                    // New activity overrides any step due on this edge.
                    state_d = ST_ON;
                    level_d = LVL_MAX;
                    div_d   = DIV_ZERO;
                end else if (cen) begin
                    if (div_q == DIV_MAX) begin
                        div_d = DIV_ZERO;
                        if (level_q <= LVL_ONE) begin
                            // Last step: leave for IDLE as level hits 0,
                            // never decrementing past zero.
                            state_d = ST_IDLE;
                            level_d = LVL_ZERO;
                        end else begin
                            state_d = ST_FADE;
                            level_d = level_q - LVL_ONE;
                        end
                    end else begin
                        state_d = ST_FADE;
                        div_d   = div_q + DIV_ONE;
                    end
                end else begin
                    state_d = ST_FADE;
                    level_d = level_q;
                    div_d   = div_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                level_d = LVL_ZERO;
                div_d   = DIV_ZERO;
            end
        endcase
    end

    // PWM generator: free-running counter and the next LED drive value.
    always_comb begin
        pwm_cnt_d = pwm_cnt_q + LVL_ONE;
        // Full scale is forced solid on; otherwise the counter comparison
        // would leave one dark slot per period at level == MAX.
        led_d = (level_q == LVL_MAX) | (pwm_cnt_q < level_q);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            level_q   <= LVL_ZERO;
            div_q     <= DIV_ZERO;
            pwm_cnt_q <= LVL_ZERO;
            led_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            level_q   <= level_d;
            div_q     <= div_d;
            pwm_cnt_q <= pwm_cnt_d;
            led_q     <= led_d;
        end
    end

    assign led   = led_q;
    assign level = level_q;
    assign busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_jtframe_led_fader.sv
// Scoreboard bench for jtframe_led_fader (PWMW=4, DIVW=2).
// Stimulus pushes hand-computed expectations tagged with the clock edge
// index they apply to. The monitor samples on every falling edge and
// compares each due entry.

module tb_jtframe_led_fader;

    logic       clk;
    logic       rst_n;
    logic       cen;
    logic       act_in;
    logic       led;
    logic [3:0] level;
    logic       busy;

    jtframe_led_fader #(.PWMW(4), .DIVW(2)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .cen    (cen),
        .act_in (act_in),
        .led    (led),
        .level  (level),
        .busy   (busy)
    );

    // kind 0: level/busy (and optionally led) check
    // kind 1: led-high count over the last 16 samples, expected in lvl
    typedef struct {
        int    at;
        int    kind;
        int    lvl;
        bit    busy;
        bit    use_led;
        bit    led;
        string name;
    } exp_t;

    exp_t sbq[$];
    bit   hist[$];
    int   cyc      = 0;
    int   total    = 0;
    int   bad      = 0;
    bit   draining = 1'b0;
    int   deadline = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void push_st(input int at, input int lvl, input bit bsy,
                                    input bit use_led, input bit ld, input string name);
        exp_t e;
        e.at = at; e.kind = 0; e.lvl = lvl; e.busy = bsy;
        e.use_led = use_led; e.led = ld; e.name = name;
        sbq.push_back(e);
    endfunction

    function automatic void push_duty(input int at, input int ones, input string name);
        exp_t e;
        e.at = at; e.kind = 1; e.lvl = ones; e.busy = 1'b0;
        e.use_led = 1'b0; e.led = 1'b0; e.name = name;
        sbq.push_back(e);
    endfunction

    // Monitor: sample outputs mid-cycle and retire every expectation due now.
    always @(negedge clk) begin : monitor
        exp_t e;
        int   ones;
        hist.push_back(led);
        if (hist.size() > 16) void'(hist.pop_front());
        while (sbq.size() > 0 && sbq[0].at <= cyc) begin
            e = sbq.pop_front();
            total++;
            if (e.at < cyc) begin
                bad++;
                $display("FAIL %s: checked at edge %0d, required at edge %0d", e.name, cyc, e.at);
            end else if (e.kind == 1) begin
                ones = 0;
                foreach (hist[i]) ones += int'(hist[i]);
                if (ones != e.lvl || hist.size() != 16) begin
                    bad++;
                    $display("FAIL %s: led high %0d of %0d clk, required %0d of 16",
                             e.name, ones, hist.size(), e.lvl);
                end
            end else if (int'(level) != e.lvl || busy != e.busy ||
                         (e.use_led && led != e.led)) begin
                bad++;
                $display("FAIL %s @edge %0d: got level=%0d busy=%0b led=%0b, required level=%0d busy=%0b led=%s",
                         e.name, cyc, level, busy, led, e.lvl, e.busy,
                         e.use_led ? (e.led ? "1" : "0") : "x");
            end
        end
        if (draining && cyc > deadline) begin
            while (sbq.size() > 0) begin
                e = sbq.pop_front();
                total++;
                bad++;
                $display("FAIL %s: never checked (due edge %0d)", e.name, e.at);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) tick();
    endtask

    // Hold reset with activity present, then release: ON after one edge,
    // LED lit one edge later. Expects rst_n already low on entry.
    task automatic start_from_reset(input string tag, output int c);
        act_in = 1'b1;
        cen    = 1'b0;
        tick();
        tick();
        c = cyc;
        push_st(c,     0,  1'b0, 1'b1, 1'b0, {tag, "_hold"});
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        push_st(c + 1, 15, 1'b1, 1'b1, 1'b0, {tag, "_on"});
        push_st(c + 2, 15, 1'b1, 1'b1, 1'b1, {tag, "_led"});
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int c, n0, m, p, q, r, c2;
        rst_n  = 1'b0;
        act_in = 1'b0;
        cen    = 1'b0;

        // Reset with activity held, then solid-on check over a full period
        start_from_reset("reset", c);
        push_duty(c + 20, 16, "duty_max");
        wait_cyc(c + 20);

        // Full fade, cen every clk: one step per 4 clk, IDLE after 60 clk
        n0     = cyc;
        act_in = 1'b0;
        cen    = 1'b1;
        for (int lv = 15; lv >= 1; lv--) begin
            push_st(n0 + 1 + 4 * (15 - lv), lv, 1'b1, 1'b0, 1'b0, "fade_first");
            push_st(n0 + 4 + 4 * (15 - lv), lv, 1'b1, 1'b0, 1'b0, "fade_last");
        end
        push_st(n0 + 61, 0, 1'b0, 1'b0, 1'b0, "fade_idle");
        push_st(n0 + 62, 0, 1'b0, 1'b1, 1'b0, "fade_led_off");
        wait_cyc(n0 + 63);

        // Single-cycle act_in pulse, then fade to 5 and freeze with cen=0
        m      = cyc;
        act_in = 1'b1;
        cen    = 1'b0;
        tick();
        act_in = 1'b0;
        cen    = 1'b1;
        push_st(m + 1,  15, 1'b1, 1'b0, 1'b0, "pulse_on");
        push_st(m + 42, 5,  1'b1, 1'b0, 1'b0, "reach_5");
        wait_cyc(m + 42);
        cen = 1'b0;
        push_st(m + 58,  5, 1'b1, 1'b0, 1'b0, "hold_5");
        push_duty(m + 58, 5, "duty_5a");
        push_st(m + 142, 5, 1'b1, 1'b0, 1'b0, "cen_off_100");
        push_duty(m + 142, 5, "duty_5b");
        wait_cyc(m + 142);

        // Prescaler untouched while cen=0: next step exactly 4 ticks away
        p   = cyc;
        cen = 1'b1;
        push_st(p + 3, 5, 1'b1, 1'b0, 1'b0, "div_kept");
        push_st(p + 4, 4, 1'b1, 1'b0, 1'b0, "div_step");
        wait_cyc(p + 4);

        // cen every 3rd clk: one step per 12 clk
        q = cyc;
        push_st(q + 11, 4, 1'b1, 1'b0, 1'b0, "cen3_pre");
        push_st(q + 12, 3, 1'b1, 1'b0, 1'b0, "cen3_step1");
        push_st(q + 23, 3, 1'b1, 1'b0, 1'b0, "cen3_pre2");
        push_st(q + 24, 2, 1'b1, 1'b0, 1'b0, "cen3_step2");
        for (int j = 1; j <= 24; j++) begin
            cen = (j % 3 == 0);
            tick();
        end

        // Re-trigger at level 7 on the edge where a step to 6 is due
        r      = cyc;
        act_in = 1'b1;
        cen    = 1'b0;
        tick();
        act_in = 1'b0;
        cen    = 1'b1;
        push_st(r + 1,  15, 1'b1, 1'b0, 1'b0, "rt_on");
        push_st(r + 34, 7,  1'b1, 1'b0, 1'b0, "rt_at7");
        push_st(r + 37, 7,  1'b1, 1'b0, 1'b0, "rt_div3");
        push_st(r + 38, 15, 1'b1, 1'b0, 1'b0, "rt_wins");
        push_st(r + 39, 15, 1'b1, 1'b1, 1'b1, "rt_fade0");
        push_st(r + 40, 15, 1'b1, 1'b1, 1'b1, "rt_solid1");
        push_st(r + 41, 15, 1'b1, 1'b1, 1'b1, "rt_solid2");
        push_st(r + 42, 15, 1'b1, 1'b1, 1'b1, "rt_div_cleared");
        push_st(r + 43, 14, 1'b1, 1'b1, 1'b1, "rt_first_step");
        wait_cyc(r + 37);
        act_in = 1'b1;
        tick();
        act_in = 1'b0;

        // Asynchronous reset mid-fade at level 9, checked before any clk edge
        push_st(r + 63, 9, 1'b1, 1'b0, 1'b0, "pre_rst_9");
        wait_cyc(r + 64);
        rst_n = 1'b0;
        push_st(r + 64, 0, 1'b0, 1'b1, 1'b0, "async_rst");
        start_from_reset("restart", c2);
        wait_cyc(c2 + 3);

        deadline = cyc + 20;
        draining = 1'b1;
        for (int k = 0; k < 25 && sbq.size() > 0; k++) tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
